// File: rtl/vis_framer.sv
// Serialises correlator visibility frames (re/im pairs ending on last) into a
// single-word AXI4-Stream: header, interleaved re/im words, then a checksum trailer.
module vis_framer #(
  parameter int          ACCUM = 32,
  parameter int          TOTAL = 30,
  parameter logic [15:0] MAGIC = 16'hA5C3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic             s_last_i,
  input  logic [ACCUM-1:0] s_revis_i,
  input  logic [ACCUM-1:0] s_imvis_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic             m_last_o,
  output logic [ACCUM-1:0] m_data_o,
  output logic [15:0]      frame_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RE,
    S_IM,
    S_TAIL
  } state_t;

  localparam logic [14:0] COUNT_MAX = 15'h7FFF;

  state_t           state_reg, state_next;
  logic             m_valid_reg, m_valid_next;
  logic             m_last_reg, m_last_next;
  logic [ACCUM-1:0] m_data_reg, m_data_next;
  logic [15:0]      frame_reg, frame_next;
  logic             err_reg, err_next;
  logic [14:0]      count_reg, count_next;
  logic [15:0]      csum_reg, csum_next;
  logic [ACCUM-1:0] im_hold_reg, im_hold_next;
  logic             last_hold_reg, last_hold_next;

  logic             load;
  logic             in_fire;
  logic             lenerr;
  logic [31:0]      header_word;
  logic [31:0]      trailer_word;

  // Only the low 32 bits of a component contribute to the checksum.
  function automatic logic [15:0] fold(input logic [ACCUM-1:0] x);
    logic [31:0] lo;
    lo = x[31:0];
    return lo[31:16] ^ lo[15:0];
  endfunction

  assign load         = !m_valid_reg || m_ready_i;
  assign s_ready_o    = (state_reg == S_RE) && load;
  assign in_fire      = s_valid_i && s_ready_o;
  assign lenerr       = (32'(count_reg) != 32'(TOTAL));
  assign header_word  = {MAGIC, frame_reg};
  assign trailer_word = {lenerr, count_reg, csum_reg};

  assign m_valid_o = m_valid_reg;
  assign m_last_o  = m_last_reg;
  assign m_data_o  = m_data_reg;
  assign frame_o   = frame_reg;
  assign err_o     = err_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      m_valid_reg   <= 1'b0;
      m_last_reg    <= 1'b0;
      m_data_reg    <= '0;
      frame_reg     <= '0;
      err_reg       <= 1'b0;
      count_reg     <= '0;
      csum_reg      <= '0;
      im_hold_reg   <= '0;
      last_hold_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      m_valid_reg   <= m_valid_next;
      m_last_reg    <= m_last_next;
      m_data_reg    <= m_data_next;
      frame_reg     <= frame_next;
      err_reg       <= err_next;
      count_reg     <= count_next;
      csum_reg      <= csum_next;
      im_hold_reg   <= im_hold_next;
      last_hold_reg <= last_hold_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    m_valid_next   = m_valid_reg;
    m_last_next    = m_last_reg;
    m_data_next    = m_data_reg;
    frame_next     = frame_reg;
    err_next       = err_reg;
    count_next     = count_reg;
    csum_next      = csum_reg;
    im_hold_next   = im_hold_reg;
    last_hold_next = last_hold_reg;

    case (state_reg)
      S_IDLE: begin
        // The pair that opens a frame is held off until the header is out.
        if (load && s_valid_i) begin
          m_data_next  = ACCUM'(header_word);
          m_valid_next = 1'b1;
          m_last_next  = 1'b0;
          count_next   = '0;
          csum_next    = '0;
          state_next   = S_RE;
        end else if (load) begin
          m_valid_next = 1'b0;
          m_last_next  = 1'b0;
        end
      end

      S_RE: begin
        if (in_fire) begin
          m_data_next    = s_revis_i;
          m_valid_next   = 1'b1;
          m_last_next    = 1'b0;
          im_hold_next   = s_imvis_i;
          last_hold_next = s_last_i;
          count_next     = (count_reg == COUNT_MAX) ? count_reg : count_reg + 15'd1;
          csum_next      = csum_reg ^ fold(s_revis_i);
          state_next     = S_IM;
        end else if (load) begin
          m_valid_next = 1'b0;
          m_last_next  = 1'b0;
        end
      end

      S_IM: begin
        if (load) begin
          m_data_next  = im_hold_reg;
          m_valid_next = 1'b1;
          m_last_next  = 1'b0;
          csum_next    = csum_reg ^ fold(im_hold_reg);
          state_next   = last_hold_reg ? S_TAIL : S_RE;
        end
      end

      S_TAIL: begin
        if (load) begin
          m_data_next  = ACCUM'(trailer_word);
          m_valid_next = 1'b1;
          m_last_next  = 1'b1;
          frame_next   = frame_reg + 16'd1;
          err_next     = err_reg | lenerr;
          state_next   = S_IDLE;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vis_framer.sv
// Randomised bench for vis_framer: a frame-level model predicts every output word,
// and a per-cycle monitor checks handshakes, hold-stability and frame/err status.
module tb_vis_framer;

  localparam int ACCUM = 32;
  localparam int TOTAL = 30;

  logic             clock = 1'b0;
  logic             reset;
  logic             s_valid_i;
  logic             s_ready_o;
  logic             s_last_i;
  logic [ACCUM-1:0] s_revis_i;
  logic [ACCUM-1:0] s_imvis_i;
  logic             m_valid_o;
  logic             m_ready_i;
  logic             m_last_o;
  logic [ACCUM-1:0] m_data_o;
  logic [15:0]      frame_o;
  logic             err_o;

  always #5 clock = ~clock;

  vis_framer #(.ACCUM(ACCUM), .TOTAL(TOTAL), .MAGIC(16'hA5C3)) dut (
    .clock(clock), .reset(reset),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_last_i(s_last_i),
    .s_revis_i(s_revis_i), .s_imvis_i(s_imvis_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_last_o(m_last_o),
    .m_data_o(m_data_o), .frame_o(frame_o), .err_o(err_o)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        hdr;
    logic [15:0] frames;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] re_a[$];
  logic [31:0] im_a[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          stall_pct = 0;
  int          beats = 0;
  logic [15:0] frame_m = 16'd0;
  logic        err_m = 1'b0;
  logic [31:0] last_header = 32'd0;
  logic [31:0] last_trailer = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [15:0] fold(input logic [31:0] x);
    return x[31:16] ^ x[15:0];
  endfunction

  // Frame-level model: expected word list from the pair lists in re_a/im_a.
  task automatic push_frame(input int n, input bit complete);
    exp_t        e;
    logic [15:0] csum = 16'd0;
    int          cnt;
    logic        le;
    e = '{data: {16'hA5C3, frame_m}, last: 1'b0, hdr: 1'b1, frames: 16'd0, err: 1'b0};
    exp_q.push_back(e);
    for (int k = 0; k < n; k++) begin
      e = '{data: re_a[k], last: 1'b0, hdr: 1'b0, frames: 16'd0, err: 1'b0};
      exp_q.push_back(e);
      e.data = im_a[k];
      exp_q.push_back(e);
      csum = csum ^ fold(re_a[k]) ^ fold(im_a[k]);
    end
    if (complete) begin
      cnt     = (n > 32767) ? 32767 : n;
      le      = (cnt != TOTAL);
      frame_m = frame_m + 16'd1;
      err_m   = err_m | le;
      e = '{data: {le, 15'(cnt), csum}, last: 1'b1, hdr: 1'b0, frames: frame_m, err: err_m};
      exp_q.push_back(e);
    end
  endtask

  task automatic send_pair(input logic [31:0] re, input logic [31:0] im, input logic last,
                           input bit first);
    int n = 0;
    s_valid_i = 1'b1;
    s_revis_i = re;
    s_imvis_i = im;
    s_last_i  = last;
    @(negedge clock);
    if (first) check("ready_low_before_header", 32'(s_ready_o), 32'd0);
    while (!s_ready_o && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (!s_ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL input_timeout: s_ready_o stayed 0, required 1");
    end
    @(posedge clock);
    #1;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic fill_pairs(input int n, input bit rnd);
    re_a.delete();
    im_a.delete();
    for (int k = 0; k < n; k++) begin
      re_a.push_back(rnd ? $urandom : 32'(k));
      im_a.push_back(rnd ? $urandom : 32'(k + 100));
    end
  endtask

  task automatic drive_pairs(input int n, input int last_at, input int gap_max);
    int g;
    for (int k = 0; k < n; k++) begin
      send_pair(re_a[k], im_a[k], (k == last_at), (k == 0));
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (g) begin
        @(posedge clock);
        #1;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clock);
    #1;
  endtask

  task automatic run_frame(input int n, input bit rnd, input int gap_max);
    fill_pairs(n, rnd);
    push_frame(n, 1'b1);
    beats = 0;
    drive_pairs(n, n - 1, gap_max);
    drain();
  endtask

  // Downstream ready with a programmable stall probability.
  initial begin
    m_ready_i = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      m_ready_i = ($urandom_range(0, 99) >= stall_pct);
    end
  end

  // Per-cycle monitor: ordered output words, hold-stability, input ready rules.
  initial begin
    exp_t        e;
    logic        prev_stall = 1'b0;
    logic        prev_in_fire = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic        prev_last = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_stall   = 1'b0;
        prev_in_fire = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 32'(m_valid_o), 32'd1);
          check("hold_data", m_data_o, prev_data);
          check("hold_last", 32'(m_last_o), 32'(prev_last));
        end
        if (m_valid_o && !m_ready_i) check("ready_low_in_stall", 32'(s_ready_o), 32'd0);
        if (prev_in_fire) check("ready_low_after_pair", 32'(s_ready_o), 32'd0);
        if (m_valid_o && m_ready_i) begin
          beats++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL extra_word: got %h required no word", m_data_o);
          end else begin
            e = exp_q.pop_front();
            $display("word data=%h last=%b frame_o=%0d err_o=%b", m_data_o, m_last_o, frame_o, err_o);
            check("word_data", m_data_o, e.data);
            check("word_last", 32'(m_last_o), 32'(e.last));
            if (e.hdr) last_header = m_data_o;
            if (e.last) begin
              last_trailer = m_data_o;
              check("frame_count", 32'(frame_o), 32'(e.frames));
              check("err_sticky", 32'(err_o), 32'(e.err));
            end
          end
        end
        prev_stall   = m_valid_o && !m_ready_i;
        prev_in_fire = s_valid_i && s_ready_o;
        prev_data    = m_data_o;
        prev_last    = m_last_o;
      end
    end
  end

  initial begin
    reset     = 1'b1;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    s_revis_i = '0;
    s_imvis_i = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_m_valid", 32'(m_valid_o), 32'd0);
    check("rst_frame", 32'(frame_o), 32'd0);
    check("rst_s_ready", 32'(s_ready_o), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Nominal frame, no stalls: hand-computed header/trailer pin the model too.
    stall_pct = 0;
    fill_pairs(TOTAL, 1'b0);
    push_frame(TOTAL, 1'b1);
    check("model_header", exp_q[0].data, 32'hA5C30000);
    check("model_trailer", exp_q[exp_q.size()-1].data, 32'h001E0000);
    beats = 0;
    drive_pairs(TOTAL, TOTAL - 1, 0);
    drain();
    check("f1_beats", 32'(beats), 32'd62);
    check("f1_header", last_header, 32'hA5C30000);
    check("f1_trailer", last_trailer, 32'h001E0000);
    check("f1_frame_o", 32'(frame_o), 32'd1);

    // Back-to-back second frame.
    run_frame(TOTAL, 1'b0, 0);
    check("f2_header", last_header, 32'hA5C30001);
    check("f2_frame_o", 32'(frame_o), 32'd2);
    check("f2_err_o", 32'(err_o), 32'd0);

    // Random data with 50% downstream stalls and input gaps.
    stall_pct = 50;
    for (int f = 0; f < 4; f++) run_frame(TOTAL, 1'b1, (f < 2) ? 0 : 3);

    // Early last at pair 10.
    fill_pairs(10, 1'b0);
    push_frame(10, 1'b1);
    drive_pairs(10, 9, 1);
    drain();
    check("early_trailer", last_trailer, 32'h800A0000);
    check("early_err_o", 32'(err_o), 32'd1);

    // Correct frame afterwards keeps err_o; then a late frame and a one-pair frame.
    run_frame(TOTAL, 1'b1, 2);
    check("err_stays", 32'(err_o), 32'd1);
    run_frame(TOTAL + 3, 1'b1, 1);
    run_frame(1, 1'b1, 0);
    check("one_pair_trailer_count", 32'(last_trailer[30:16]), 32'd1);

    // Reset mid-frame after 5 pairs: no trailer, everything clears at once.
    stall_pct = 0;
    fill_pairs(5, 1'b1);
    push_frame(5, 1'b0);
    drive_pairs(5, -1, 0);
    drain();
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_m_valid", 32'(m_valid_o), 32'd0);
    check("mid_rst_m_last", 32'(m_last_o), 32'd0);
    check("mid_rst_m_data", m_data_o, 32'd0);
    check("mid_rst_s_ready", 32'(s_ready_o), 32'd0);
    check("mid_rst_frame", 32'(frame_o), 32'd0);
    check("mid_rst_err", 32'(err_o), 32'd0);
    frame_m = 16'd0;
    err_m   = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    stall_pct = 30;
    run_frame(TOTAL, 1'b1, 1);
    check("post_rst_header", last_header, 32'hA5C30000);
    repeat (5) @(posedge clock);
    check("no_spurious_trailer", 32'(exp_q.size()), 32'd0);

    // Frame counter wrap.
    @(posedge clock);
    #1;
    force dut.frame_reg = 16'hFFFF;
    @(posedge clock);
    #1;
    release dut.frame_reg;
    frame_m = 16'hFFFF;
    run_frame(1, 1'b1, 0);
    check("wrap_header", last_header, 32'hA5C3FFFF);
    check("wrap_frame_o", 32'(frame_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vis_framer.md
Name: vis_framer

Overview:
- Sits directly downstream of the correlator's AXI4-Stream visibility output (re/im accumulator pairs, one frame per TOTAL pairs, terminated by last).
- Serialises each frame into a single-word AXI4-Stream for the host link.
- Each output frame is one header word, then re and im words interleaved, then one trailer word carrying the length-error flag, pair count and checksum.
- Single clock domain; registered output stage with a full valid/ready handshake.

Parameters:
- ACCUM, 32, bit-width of each visibility component and of output words (must be >= 32)
- TOTAL, 30, expected visibility pairs per frame (CORES*TRATE)
- MAGIC, 16'hA5C3, constant placed in header bits [31:16]

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- s_valid_i  in  1  input visibility pair valid
- s_ready_o  out  1  input ready
- s_last_i  in  1  marks final pair of a frame
- s_revis_i  in  ACCUM  real component
- s_imvis_i  in  ACCUM  imaginary component
- m_valid_o  out  1  output word valid
- m_ready_i  in  1  downstream ready
- m_last_o  out  1  marks trailer word
- m_data_o  out  ACCUM  output word
- frame_o  out  16  count of completed frames
- err_o  out  1  sticky: at least one frame had a length error

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - state=IDLE; m_valid_o, m_last_o, m_data_o, s_ready_o, frame_o, err_o, pair count and checksum all 0.
  - Any partially emitted frame is abandoned, with no trailer.
- Output register load condition: load = !m_valid_o | m_ready_i. m_valid_o/m_data_o/m_last_o change only when load=1.
- s_ready_o is combinational: 1 only when state==RE and load==1.
- IDLE:
  - If s_valid_i & load: m_data_o<={MAGIC, frame_o}, m_valid_o<=1, m_last_o<=0, count<=0, csum<=0, state->RE.
  - Input is not consumed in this cycle.
  - If load & !s_valid_i: m_valid_o<=0.
- RE:
  - On an input handshake (s_valid_i & s_ready_o): m_data_o<=s_revis_i, im_hold<=s_imvis_i, last_hold<=s_last_i, count<=sat(count+1), csum^=fold(s_revis_i), state->IM.
  - If load & !s_valid_i: m_valid_o<=0 (bubble), stay in RE.
- IM:
  - On load: m_data_o<=im_hold, m_valid_o<=1, csum^=fold(im_hold).
  - Next state is TAIL if last_hold, else RE.
- TAIL:
  - On load: m_data_o<={lenerr, count[14:0], csum}, m_last_o<=1, m_valid_o<=1.
  - lenerr = (count != TOTAL).
  - frame_o<=frame_o+1, wrapping 16'hFFFF->0.
  - err_o<=err_o | lenerr.
  - state->IDLE.
- m_last_o clears on the next load that presents a non-trailer word.
- fold(x) = x[31:16] ^ x[15:0]. Only the low 32 bits are used when ACCUM>32.
- Pair count is 15 bits and saturates at 32767; the frame continues.
- Header and trailer words: bits above 31 are zero when ACCUM>32.
- Latency: a header word is valid 1 cycle after s_valid_i is seen in IDLE. Each data word is registered 1 cycle after its load.
- Throughput: at most 1 pair per 2 cycles, so s_ready_o is low at least every other cycle. Frame cost is 2*N+2 output beats.
- Back-pressure: while m_valid_o & !m_ready_i, m_data_o/m_last_o hold stable and s_ready_o=0.
- Frame length mismatch: s_last_i early or late still terminates the frame on s_last_i. Only the trailer flag and err_o report the mismatch.
- s_last_i on the first pair: frame is header, re, im, trailer with count=1.

Test Plan:
- Reset, then TOTAL=30 pairs with re=k, im=k+100 and last on k=29, m_ready_i=1 -> 62 beats:
  - header 32'hA5C30000;
  - then 0,100,1,101,…;
  - trailer bit31=0, count=30, csum = XOR of fold of all 60 words;
  - m_last_o only on the trailer; frame_o=1.
- Two back-to-back frames -> second header is 32'hA5C30001; frame_o=2; s_ready_o never high in IDLE or IM.
- Random m_ready_i stalls (50%) -> data/last stable while stalled; output sequence identical to the unstalled run; no word lost or duplicated.
- Early last at pair 10 -> trailer bit31=1, count=10; err_o=1 and remains 1 through a following correct frame.
- Assert reset mid-frame after 5 pairs -> all outputs 0 immediately (asynchronous); next input starts a fresh header with frame number 0.
- Force frame_o to 16'hFFFF via 65535 one-pair frames (or a bench force) -> next header low half is 16'hFFFF; frame_o wraps to 0.
